// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr
// Registered N-way arbiter with fixed-priority or round-robin selection.
// A grant is held under a valid/ack handshake until the consumer acks it.
// At least one idle cycle separates two grants. The round-robin pointer
// (last_idx) records the most recently completed grant.
// Fixed priority: the highest set request index wins.
// Round-robin: the search descends from last_idx-1 with wrap-around.

module priority_arbiter_rr #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            rr_en_i,
    input  logic            ack_i,
    output logic            grant_valid_o,
    output logic [IDXW-1:0] grant_idx_o,
    output logic [N-1:0]    grant_onehot_o,
    output logic [IDXW-1:0] last_idx_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Winner selection helpers
    // ------------------------------------------------------------------

    // Highest set index wins. Later (higher) hits overwrite earlier ones.
    function automatic logic [IDXW-1:0] fixed_winner(input logic [N-1:0] req);
        logic [IDXW-1:0] win;
        win = {IDXW{1'b0}};
        for (int i = 0; i < N; i++) begin
            win = req[i] ? IDXW'(i) : win;
        end
        return win;
    endfunction

    // Search order is last-1, last-2, ... wrapping, ending at last itself.
    // The loop walks that order backwards (k = N down to 1), so the entry
    // closest to last-1 is written last and therefore takes precedence.
    function automatic logic [IDXW-1:0] rr_winner(input logic [N-1:0]    req,
                                                  input logic [IDXW-1:0] last);
        logic [IDXW-1:0] win;
        int              pos;
        win = {IDXW{1'b0}};
        pos = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last) + N - k) % N;
            win = req[pos] ? IDXW'(pos) : win;
        end
        return win;
    endfunction

    // Index to one-hot. Index values at or above N give all zeros; they
    // cannot occur because winners are always below N.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        logic [N-1:0] oh;
        oh = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            oh[i] = (idx == IDXW'(i));
        end
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]    grant_onehot_q, grant_onehot_d;
    logic [IDXW-1:0] last_idx_q, last_idx_d;

    logic [IDXW-1:0] winner_idx;
    logic            any_req;

    // Arbitration result for the current request vector. It is only
    // consumed in IDLE, so rr_en_i has no effect while a grant is held.
    always_comb begin
        any_req    = (req_i != {N{1'b0}});
        winner_idx = {IDXW{1'b0}};
        if (rr_en_i) begin
            winner_idx = rr_winner(req_i, last_idx_q);
        end else begin
            winner_idx = fixed_winner(req_i);
        end
    end

    // State register and registered outputs. The async reset clears all
    // of them immediately, including mid-grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= {IDXW{1'b0}};
            grant_onehot_q <= {N{1'b0}};
            last_idx_q     <= {IDXW{1'b0}};
        end else begin
            state_q        <= state_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            last_idx_q     <= last_idx_d;
        end
    end

    // Next-state logic. IDLE -> GRANT on any request. GRANT -> IDLE on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values for the registered outputs.
    // The grant is latched in IDLE and frozen in GRANT. On ack, the grant
    // is released and the pointer is updated. grant_idx is kept after
    // release so the last winner remains observable.
    always_comb begin
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        last_idx_d     = last_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = winner_idx;
                    grant_onehot_d = idx_to_onehot(winner_idx);
                end else begin
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = {N{1'b0}};
                end
            end
            ST_GRANT: begin
                if (ack_i) begin
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = {N{1'b0}};
                    last_idx_d     = grant_idx_q;
                end else begin
                    grant_valid_d  = 1'b1;
                    grant_onehot_d = grant_onehot_q;
                end
            end
            default: begin
                grant_valid_d  = 1'b0;
                grant_onehot_d = {N{1'b0}};
            end
        endcase
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_idx_o    = grant_idx_q;
    assign grant_onehot_o = grant_onehot_q;
    assign last_idx_o     = last_idx_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Testbench for priority_arbiter_rr (N = 4).
// The main stimulus is a table of directed vectors applied one clock per
// entry. Hand-written sequences then cover the asynchronous reset timing
// and the minimum gap between grants.

module tb_priority_arbiter_rr;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic [N-1:0]    req   = 4'b0000;
    logic            rr_en = 1'b0;
    logic            ack   = 1'b0;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic [N-1:0]    grant_onehot;
    logic [IDXW-1:0] last_idx;

    always #5 clk = ~clk;

    priority_arbiter_rr #(.N(N), .IDXW(IDXW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .rr_en_i        (rr_en),
        .ack_i          (ack),
        .grant_valid_o  (grant_valid),
        .grant_idx_o    (grant_idx),
        .grant_onehot_o (grant_onehot),
        .last_idx_o     (last_idx)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       rr_en;
        logic       ack;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [3:0] exp_oh;
        logic [1:0] exp_last;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input string nm, input logic r, input logic [3:0] rq,
                       input logic rr, input logic ak, input logic ev,
                       input logic [1:0] ei, input logic [3:0] eo, input logic [1:0] el);
        vec_t v;
        v.name = nm; v.rst = r; v.req = rq; v.rr_en = rr; v.ack = ak;
        v.exp_valid = ev; v.exp_idx = ei; v.exp_oh = eo; v.exp_last = el;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic ev, input logic [1:0] ei,
                         input logic [3:0] eo, input logic [1:0] el);
        n_checks++;
        if (grant_valid === ev && grant_idx === ei && grant_onehot === eo && last_idx === el) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got valid=%b idx=%0d onehot=%b last=%0d, want valid=%b idx=%0d onehot=%b last=%0d",
                     nm, grant_valid, grant_idx, grant_onehot, last_idx, ev, ei, eo, el);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance edges until grant_valid is seen or the budget runs out.
    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        while (!grant_valid && edges < budget) begin
            step();
            edges++;
        end
    endtask

    initial begin
        int e;

        //     name              rst req    rr    ack   valid idx   onehot  last
        // Test 1: reset, then the first grant after reset release.
        add("t1_rst_edge",       1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
        add("t1_first_grant",    1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd0);
        // Test 2: fixed-priority hold and release.
        add("t2_release0",       1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t2_grant3",         1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t2_hold_a",         1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t2_hold_b",         1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t2_hold_c",         1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t2_ack",            1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t2_grant1",         1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd3);
        // Test 3: fixed-priority starvation; index 3 wins every time.
        add("t3_ack0",           1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 2'd1);
        add("t3_g1",             1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd1);
        add("t3_ack1",           1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t3_g2",             1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t3_ack2",           1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t3_g3",             1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t3_ack3",           1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t3_g4",             1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3);
        add("t3_ack4",           1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        // Test 4: round-robin rotation 3,2,1,0,3 after a reset.
        add("t4_rst",            1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0);
        add("t4_g3",             1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd0);
        add("t4_ack3",           1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t4_g2",             1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3);
        add("t4_ack2",           1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd2);
        add("t4_g1",             1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd2);
        add("t4_ack1",           1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 2'd1);
        add("t4_g0",             1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd1);
        add("t4_ack0",           1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0);
        add("t4_g3_wrap",        1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd0);
        // Test 5: round-robin skip and wrap with req = 1001.
        add("t5_ack",            1'b0, 4'h9, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t5_skip_to0",       1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd3);
        add("t5_ack0",           1'b0, 4'h9, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0);
        add("t5_wrap_to3",       1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd0);
        // Test 6a: ack in IDLE with no requests changes nothing.
        add("t6_ack3",           1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t6_idle_ack",       1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd3);
        add("t6_idle_quiet",     1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 2'd3);
        // rr_en is ignored while a grant is held, but is used at arbitration.
        add("mode_fixed_g2",     1'b0, 4'h4, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3);
        add("mode_rr_ignored",   1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd3);
        add("mode_ack2",         1'b0, 4'h6, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd2);
        add("mode_rr_picks1",    1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd2);

        // Asynchronous reset at start-up with all requests high.
        req = 4'hF;
        #2 rst = 1'b1;
        #1 check("rst_async_initial", 1'b0, 2'd0, 4'b0000, 2'd0);

        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            req   = vecs[i].req;
            rr_en = vecs[i].rr_en;
            ack   = vecs[i].ack;
            step();
            check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_oh, vecs[i].exp_last);
        end

        // Reset mid-GRANT (idx 1 held, last 2): outputs clear before the next edge.
        ack = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_async_midgrant", 1'b0, 2'd0, 4'b0000, 2'd0);
        req   = 4'h0;
        rr_en = 1'b0;
        step();
        check("rst_held", 1'b0, 2'd0, 4'b0000, 2'd0);

        // After reset release, the first grant appears one edge later.
        rst = 1'b0;
        req = 4'h8;
        wait_valid(4, e);
        check_int("latency_after_rst", e, 1);
        check("grant_after_rst", 1'b1, 2'd3, 4'b1000, 2'd0);

        // req changes on the ack edge; the new req is judged one edge later.
        ack = 1'b1;
        req = 4'h1;
        step();
        check("ack_with_req_change", 1'b0, 2'd3, 4'b0000, 2'd3);
        ack = 1'b0;
        wait_valid(6, e);
        check_int("gap_after_ack", e, 1);
        check("grant_new_req", 1'b1, 2'd0, 4'b0001, 2'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
